// File: rtl/elastic_pipe_n.sv
// ---------------------------------------------------------------------------
// elastic_pipe_n
//   Parametrised chain of DEPTH elastic pipeline registers with a valid/ready
//   handshake, bubble collapse and a per-stage flush (squash). One instance
//   carries an arbitrary payload bundle between two datapath stages.
//
//   Stage DEPTH-1 drives the output. Ready propagates combinationally from
//   out_ready back to in_ready, so there is no skid buffer.
//   A flushed stage drops the item it holds. It also drops any item that
//   would enter it in the same cycle. For the stage in front of it, a flushed
//   stage counts as free, so a flush never stalls upstream stages.
//
// Parameters
//   WIDTH      payload bits per stage
//   DEPTH      number of register stages (>= 1)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all valid bits and data
//   in_valid   upstream presents in_data
//   in_ready   chain accepts in_data this cycle
//   in_data    payload entering stage 0
//   out_valid  stage DEPTH-1 holds an item
//   out_ready  downstream consumes out_data this cycle
//   out_data   payload of stage DEPTH-1
//   occ        items currently held (only with PIPE_OCC_COUNT_EN)
//   flush      flush[i] squashes stage i
//
// Configuration
//   PIPE_OCC_COUNT_EN  when defined, adds the occ port and its counter.
// ---------------------------------------------------------------------------
module elastic_pipe_n #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef PIPE_OCC_COUNT_EN
  output logic [$clog2(DEPTH+1)-1:0] occ,
`endif
  input  logic [DEPTH-1:0] flush
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] load_d;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d_q   [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];

  // adv[i] = stage i may load this cycle. Bit DEPTH stands for the consumer,
  // so the output stage uses the same recurrence as every other stage.
  logic [DEPTH:0] adv;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // an unassigned path would infer a latch.
    adv        = '0;
    adv[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = ~v_q[i] | flush[i] | adv[i+1];
    end
  end

  // What would enter each stage: stage 0 takes the input port. Every other
  // stage takes its predecessor, unless that predecessor is being flushed.
  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v_q[i-1] & ~flush[i-1];
      src_d[i] = d_q[i-1];
    end
  end

  // A flushed stage ends empty, even when it loads. An advancing stage takes
  // whatever arrives, which may be a bubble. A stalled stage keeps its item.
  always_comb begin
    v_d    = v_q;
    load_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush[i]) begin
        v_d[i] = 1'b0;
      end else if (adv[i]) begin
        v_d[i]    = src_v[i];
        load_d[i] = src_v[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      // NOTE: the payload registers are reset as well, because out_data must
      // read zero after reset and not hold stale contents.
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so that every
      // stage samples its predecessor's pre-edge value.
      v_q <= v_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (load_d[i]) begin
          d_q[i] <= src_d[i];
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

`ifdef PIPE_OCC_COUNT_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Next occupancy is the population of next-cycle valid bits. This count
  // includes new accepts and excludes consumed items and flushed items,
  // without counting any item twice. The case that matters is flush[DEPTH-1]
  // together with out_ready: that item is dropped and counted once.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(v_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_elastic_pipe_n.sv
// ---------------------------------------------------------------------------
// tb_elastic_pipe_n
//   Self-checking bench for elastic_pipe_n (WIDTH=32, DEPTH=4).
//
//   The bench has three parts:
//     - a table of stream vectors;
//     - hand-written multi-cycle sequences: back-pressure, bubble collapse,
//       flush, flush with a full chain, and asynchronous reset;
//     - randomized traffic, compared every cycle against a slot-level
//       reference model.
//
//   In the reference model, a stage is stuck only when it and every stage
//   after it hold an unflushed item while the consumer is not ready.
//   Everything else moves forward one slot per cycle.
//   Define PIPE_OCC_COUNT_EN to also check occ.
// ---------------------------------------------------------------------------
module tb_elastic_pipe_n;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [D-1:0] flush;
`ifdef PIPE_OCC_COUNT_EN
  logic [$clog2(D+1)-1:0] occ;
`endif

  elastic_pipe_n #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef PIPE_OCC_COUNT_EN
    .occ       (occ),
`endif
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    logic [31:0] d;
  } slot_t;

  slot_t m [D];

  function automatic void model_reset();
    for (int i = 0; i < D; i++) begin
      m[i].v = 1'b0;
      m[i].d = '0;
    end
  endfunction

  // Stage i cannot move if it and every later stage hold an unflushed item
  // and the consumer is not taking anything.
  function automatic bit stuck(int i);
    bit s = !out_ready;
    for (int j = i; j < D; j++) begin
      s = s && m[j].v && !flush[j];
    end
    return s;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < D; i++) begin
      n += int'(m[i].v);
    end
    return n;
  endfunction

  function automatic void model_step();
    slot_t n [D];
    for (int i = 0; i < D; i++) begin
      n[i] = m[i];
      if (flush[i]) begin
        n[i].v = 1'b0;
      end else if (!stuck(i)) begin
        if (i == 0) begin
          n[0].v = in_valid;
          n[0].d = in_data;
        end else if (m[i-1].v && !flush[i-1]) begin
          n[i] = m[i-1];
        end else begin
          n[i].v = 1'b0;
        end
      end
    end
    m = n;
  endfunction

  // ---------------- cycle helpers ----------------
  // Inputs are driven just after the falling edge. Outputs are sampled 1 ns
  // later, well before the next rising edge.
  task automatic drive(input logic iv, input logic [31:0] id, input logic ordy, input logic [D-1:0] fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    #1;
    check("model_in_ready", 32'(in_ready), 32'(!stuck(0)));
    check("model_out_valid", 32'(out_valid), 32'(m[D-1].v));
    if (m[D-1].v) check("model_out_data", out_data, m[D-1].d);
`ifdef PIPE_OCC_COUNT_EN
    check("model_occ", 32'(occ), 32'(model_count()));
`endif
    model_step();
    @(negedge clk);
  endtask

  logic [31:0] got [$];

  task automatic drain(input int n);
    got.delete();
    repeat (n) begin
      drive(1'b0, '0, 1'b1, '0);
      #1;
      if (out_valid) got.push_back(out_data);
      tick();
    end
  endtask

  task automatic compare_q(input string name, input logic [31:0] exp [$]);
    check({name, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check(name, got[i], exp[i]);
    end
  endtask

  // ---------------- stream vector table ----------------
  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic [D-1:0] fl;
    logic        eov;
    logic [31:0] eod;
    logic        eir;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] exp_q [$];

    // Items 0x1..0x8 on consecutive cycles with out_ready held high.
    // Item k is accepted in cycle k-1 and is presented in cycle k+3,
    // so the outputs run from cycle 4 to cycle 11 without gaps.
    for (int k = 0; k < 12; k++) begin
      tbl[k].iv   = (k < 8);
      tbl[k].id   = (k < 8) ? 32'(k + 1) : 32'h0;
      tbl[k].ordy = 1'b1;
      tbl[k].fl   = '0;
      tbl[k].eov  = (k >= 4);
      tbl[k].eod  = (k >= 4) ? 32'(k - 3) : 32'h0;
      tbl[k].eir  = 1'b1;
    end

    // ---- reset state ----
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_data", out_data, 32'h0);
`ifdef PIPE_OCC_COUNT_EN
    check("rst_occ", 32'(occ), 32'(0));
`endif
    @(negedge clk);
    reset = 1'b0;

    // ---- empty chain: in_ready high regardless of out_ready ----
    drive(1'b0, '0, 1'b0, '0);
    #1;
    check("empty_in_ready", 32'(in_ready), 32'(1));
    tick();

    // ---- table-driven stream ----
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].iv, tbl[k].id, tbl[k].ordy, tbl[k].fl);
      #1;
      check("stream_in_ready", 32'(in_ready), 32'(tbl[k].eir));
      check("stream_out_valid", 32'(out_valid), 32'(tbl[k].eov));
      if (tbl[k].eov) check("stream_out_data", out_data, tbl[k].eod);
      tick();
    end

    // ---- back-pressure: four accepts fill the chain, then it holds ----
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 32'hA0 + 32'((c < 4) ? c : 4), 1'b0, '0);
      #1;
      check("bp_in_ready", 32'(in_ready), 32'(c < 4));
      if (c >= 4) check("bp_hold_data", out_data, 32'hA0);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, '0, 1'b1, '0);
      #1;
      check("bp_drain_valid", 32'(out_valid), 32'(1));
      check("bp_drain_data", out_data, 32'hA0 + 32'(c));
      tick();
    end

    // ---- bubble collapse: B0, two idle cycles, B1, consumer stalled ----
    for (int c = 0; c < 7; c++) begin
      drive(c == 0 || c == 3, (c == 0) ? 32'hB0 : 32'hB1, 1'b0, '0);
      #1;
      check("bubble_in_ready", 32'(in_ready), 32'(1));
      tick();
    end
    drain(3);
    exp_q = '{32'hB0, 32'hB1};
    compare_q("bubble_out", exp_q);

    // ---- flush 0110: C0 in stage 3, C1/C2 in stages 2/1, C3 arriving ----
    for (int c = 0; c < 4; c++) begin
      drive(c < 3, 32'hC0 + 32'(c), 1'b0, '0);
      tick();
    end
    drive(1'b1, 32'hC3, 1'b0, 4'b0110);
`ifdef PIPE_OCC_COUNT_EN
    #1;
    check("flush_occ_before", 32'(occ), 32'(3));
`endif
    tick();
`ifdef PIPE_OCC_COUNT_EN
    drive(1'b0, '0, 1'b0, '0);
    #1;
    check("flush_occ_after", 32'(occ), 32'(2));
`endif
    drain(8);
    exp_q = '{32'hC0, 32'hC3};
    compare_q("flush_out", exp_q);

    // ---- flush[3] while full and stalled: in_ready high in the same cycle ----
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 32'hD0 + 32'(c), 1'b0, '0);
      tick();
    end
    drive(1'b1, 32'hD4, 1'b0, 4'b1000);
    #1;
    check("flushfull_in_ready", 32'(in_ready), 32'(1));
    tick();
    drain(8);
    // D0 is squashed in stage 3; D1 moves into the flushed stage and is dropped.
    exp_q = '{32'hD2, 32'hD3, 32'hD4};
    compare_q("flushfull_out", exp_q);

    // ---- all-ones flush empties the chain in one cycle ----
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'hE0 + 32'(c), 1'b0, '0);
      tick();
    end
    drive(1'b1, 32'hE3, 1'b0, 4'b1111);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    #1;
    check("flushall_out_valid", 32'(out_valid), 32'(0));
    tick();

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 1500; c++) begin
      logic [D-1:0] fl;
      for (int i = 0; i < D; i++) fl[i] = ($urandom_range(0, 15) == 0);
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6, fl);
      tick();
    end

    // ---- asynchronous reset in the middle of a clock phase ----
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 32'hF0 + 32'(c), 1'b0, '0);
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'(0));
    check("async_rst_in_ready", 32'(in_ready), 32'(1));
    check("async_rst_out_data", out_data, 32'h0);
`ifdef PIPE_OCC_COUNT_EN
    check("async_rst_occ", 32'(occ), 32'(0));
`endif
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 32'h55, 1'b1, '0);
    for (int c = 0; c < 6; c++) begin
      tick();
      drive(1'b0, '0, 1'b1, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
